// File: rtl/otter_mem_arbiter.sv
// Arbitrates the OTTER fetch (IF) and data (DM) ports onto one variable-latency memory, one transaction at a time.
// Optional starvation guard for the fetch port is enabled by defining ARB_STARVE_GUARD_EN.
module otter_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_size,
  input  logic        dm_sign,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_sign,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERV_I = 2'd1;
  localparam logic [1:0] SERV_D = 2'd2;

  logic [1:0] state;
  logic       drop;
  logic       starve_force;
  logic       grant_d;
  logic       grant_i;

  if (STARVE_LIMIT >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold STARVE_LIMIT");
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt;

  // Counts data grants that jumped a pending fetch; at the limit the fetch wins.
  assign starve_force = (starve_cnt == CNT_W'(STARVE_LIMIT)) && if_req && !if_flush;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && if_req && !if_flush && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  assign grant_d = (state == IDLE) && dm_req && !starve_force;
  assign grant_i = (state == IDLE) && !grant_d && if_req && !if_flush;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      drop      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      mem_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= SERV_D;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_size  <= dm_size;
            mem_sign  <= dm_sign;
          end else if (grant_i) begin
            state    <= SERV_I;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            mem_size <= 2'b10;
            mem_sign <= 1'b0;
          end
        end
        SERV_I: begin
          // Memory cannot abort, so a squashed fetch runs on and its data is discarded.
          if (mem_rvalid) begin
            state <= IDLE;
            drop  <= 1'b0;
          end else if (if_flush) begin
            drop <= 1'b1;
          end
        end
        SERV_D: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req  = (state != IDLE);
  assign if_valid = (state == SERV_I) && mem_rvalid && !drop && !if_flush;
  assign dm_valid = (state == SERV_D) && mem_rvalid;
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;
  assign if_stall = if_req && !if_valid;
  assign dm_stall = dm_req && !dm_valid;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: memory responses are driven by hand, expectations are fixed constants.
module tb_otter_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_sign, dm_valid, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [1:0]  dm_size;
  logic        mem_req, mem_we, mem_sign, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  int checks = 0;
  int errors = 0;

  otter_mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_size(dm_size), .dm_sign(dm_sign),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 1 time unit later.
  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1;
    if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_size = '0; dm_sign = 0;
    mem_rvalid = 0; mem_rdata = '0;
    repeat (2) @(posedge CLK);

    // Reset then idle
    cyc(); RESET = 1'b0; #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_dm_valid", dm_valid, 0);
    check("rst_if_stall", if_stall, 0);
    check("rst_dm_stall", dm_stall, 0);
    check("rst_mem_addr", mem_addr, 0);
    mem_rvalid = 1; #1;
    check("idle_rvalid_if", if_valid, 0);
    check("idle_rvalid_dm", dm_valid, 0);
    mem_rvalid = 0;

    // Flush in IDLE blocks the grant
    cyc(); if_req = 1; if_flush = 1; if_addr = 32'h180; #1;
    check("idle_flush_stall", if_stall, 1);

    // Single fetch
    cyc(); if_flush = 0; if_addr = 32'h100; #1;
    check("idle_flush_no_grant", mem_req, 0);
    check("fetch_stall_0", if_stall, 1);
    cyc(); #1;
    check("fetch_mem_req", mem_req, 1);
    check("fetch_mem_addr", mem_addr, 32'h100);
    check("fetch_mem_we", mem_we, 0);
    check("fetch_mem_size", mem_size, 2'b10);
    check("fetch_no_valid", if_valid, 0);
    check("fetch_stall_1", if_stall, 1);
    cyc(); mem_rvalid = 1; mem_rdata = 32'h00500093; #1;
    check("fetch_valid", if_valid, 1);
    check("fetch_rdata", if_rdata, 32'h00500093);
    check("fetch_stall_done", if_stall, 0);
    cyc(); if_req = 0; mem_rvalid = 0; #1;
    check("fetch_idle_after", mem_req, 0);
    check("fetch_single_pulse", if_valid, 0);

    // Simultaneous requests: data first
    cyc(); if_req = 1; if_addr = 32'h300;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_size = 2'd2; dm_sign = 0; #1;
    check("sim_dm_stall", dm_stall, 1);
    cyc(); mem_rvalid = 1; mem_rdata = 32'h11111111; #1;
    check("sim_d_mem_we", mem_we, 1);
    check("sim_d_mem_addr", mem_addr, 32'h2000);
    check("sim_d_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("sim_d_mem_size", mem_size, 2'd2);
    check("sim_dm_valid", dm_valid, 1);
    check("sim_dm_stall_done", dm_stall, 0);
    check("sim_if_waits", if_valid, 0);
    check("sim_if_stall", if_stall, 1);
    cyc(); dm_req = 0; dm_we = 0; mem_rvalid = 0; #1;
    check("sim_gap_idle", mem_req, 0);
    check("sim_gap_dm_valid", dm_valid, 0);
    cyc(); mem_rvalid = 1; mem_rdata = 32'h00A00113; #1;
    check("sim_i_mem_addr", mem_addr, 32'h300);
    check("sim_i_mem_we", mem_we, 0);
    check("sim_i_valid", if_valid, 1);
    check("sim_i_rdata", if_rdata, 32'h00A00113);
    cyc(); if_req = 0; mem_rvalid = 0; #1;
    check("sim_end_idle", mem_req, 0);

    // Flush while a fetch is in flight
    cyc(); if_req = 1; if_addr = 32'h104; #1;
    cyc(); if_flush = 1; #1;
    check("flush_mem_addr", mem_addr, 32'h104);
    check("flush_no_valid", if_valid, 0);
    cyc(); if_flush = 0; if_addr = 32'h200; mem_rvalid = 1; mem_rdata = 32'h0000BAD0; #1;
    check("flush_dropped", if_valid, 0);
    check("flush_stall", if_stall, 1);
    cyc(); mem_rvalid = 0; #1;
    check("flush_idle", mem_req, 0);
    cyc(); mem_rvalid = 1; mem_rdata = 32'h00000013; #1;
    check("refetch_addr", mem_addr, 32'h200);
    check("refetch_valid", if_valid, 1);
    check("refetch_rdata", if_rdata, 32'h00000013);
    cyc(); if_req = 0; mem_rvalid = 0; #1;

    // Reset in the middle of a data transaction
    cyc(); dm_req = 1; dm_we = 0; dm_addr = 32'h40; dm_size = 2'd2; dm_sign = 1; #1;
    cyc(); #1;
    check("rmid_mem_req", mem_req, 1);
    check("rmid_mem_sign", mem_sign, 1);
    RESET = 1;
    cyc(); mem_rvalid = 1; #1;
    check("rmid_req_drop", mem_req, 0);
    check("rmid_no_dm_valid", dm_valid, 0);
    check("rmid_addr_clr", mem_addr, 0);
    cyc(); RESET = 0; dm_req = 0; dm_sign = 0; mem_rvalid = 0; #1;
    check("rmid_idle", mem_req, 0);

    // Starvation: both ports held continuously
    cyc(); if_req = 1; if_addr = 32'h400; dm_req = 1; dm_we = 0; dm_addr = 32'h800;
    for (int g = 0; g < 6; g++) begin
      logic [31:0] exp_addr;
`ifdef ARB_STARVE_GUARD_EN
      exp_addr = (g == 4) ? 32'h400 : 32'h800;
`else
      exp_addr = 32'h800;
`endif
      #1 check($sformatf("starve_idle_%0d", g), mem_req, 0);
      cyc(); mem_rvalid = 1; mem_rdata = 32'h1000 + 32'(g); #1;
      check($sformatf("starve_grant_%0d", g), mem_addr, exp_addr);
      check($sformatf("starve_ifv_%0d", g), if_valid, (exp_addr == 32'h400) ? 1 : 0);
      cyc(); mem_rvalid = 0;
    end
    if_req = 0; dm_req = 0;
    cyc(); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between two requesters: the pipeline's instruction-fetch (IF) port and the MEM-stage data port (DM).
- Sits between the pipelined OTTER core and the unified memory.
- Arbitrates with fixed data priority and keeps one transaction outstanding.
- Generates per-port stall signals and discards fetches squashed by a taken branch.

Parameters:
STARVE_LIMIT, 4, consecutive DM grants allowed while IF waits, before IF is forced a grant (used only with the optional feature)
CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high until if_valid or if_flush
if_addr  in  32  fetch byte address
if_flush  in  1  taken branch/jump; squash any fetch in flight
if_rdata  out  32  fetched instruction
if_valid  out  1  fetch complete (one-cycle pulse)
if_stall  out  1  fetch port must hold
dm_req  in  1  data request; held until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_addr  in  32  data byte address
dm_wdata  in  32  store data
dm_size  in  2  access size, funct3[1:0] encoding
dm_sign  in  1  load sign flag, funct3[2]
dm_rdata  out  32  load data
dm_valid  out  1  data access complete (one-cycle pulse)
dm_stall  out  1  data port must hold
mem_req  out  1  memory request; held until mem_rvalid
mem_we  out  1  write enable
mem_addr  out  32  address
mem_wdata  out  32  write data
mem_size  out  2  size
mem_sign  out  1  sign
mem_rvalid  in  1  memory completes the current request (reads and writes)
mem_rdata  in  32  read data, valid with mem_rvalid

Behaviour:
- FSM states:
  - IDLE: no transaction outstanding.
  - SERV_I: serving a fetch.
  - SERV_D: serving a data access.
- Reset values: state = IDLE; mem_req = 0; mem_we = 0; mem_addr, mem_wdata, mem_size, mem_sign = 0; if_valid = dm_valid = 0; drop flag = 0; starvation counter = 0.
- IDLE arbitration, registered:
  - dm_req = 1: go to SERV_D. Latch dm_we, dm_addr, dm_wdata, dm_size, dm_sign into the mem_* registers.
  - dm_req = 0 and if_req = 1 and if_flush = 0: go to SERV_I. Latch if_addr. Force mem_we = 0, mem_size = 2'b10, mem_sign = 0.
  - Neither: stay in IDLE.
- mem_req = 1 exactly while the state is SERV_I or SERV_D. Request fields are stable for the whole transaction.
- Completion:
  - mem_rvalid is sampled only in a SERV state. It may arrive in the first SERV cycle (minimum latency: grant cycle plus one).
  - SERV_D with mem_rvalid: dm_valid = 1 and dm_rdata = mem_rdata, both combinational in the same cycle. Next state is IDLE.
  - SERV_I with mem_rvalid: if_valid = 1 and if_rdata = mem_rdata, unless the drop flag is set or if_flush = 1 in that cycle; then if_valid stays 0. Next state is IDLE and the drop flag clears.
- Throughput: the cycle after a completion is always IDLE, so back-to-back transactions take at least 2 cycles each.
- Stalls, combinational:
  - if_stall = if_req & ~if_valid.
  - dm_stall = dm_req & ~dm_valid.
- Flush:
  - if_flush in SERV_I without mem_rvalid sets the drop flag. The transaction still runs to completion, because memory cannot abort.
  - if_flush in IDLE blocks an IF grant that cycle.
  - if_flush in SERV_D has no effect.
- Outside the completion rules above, mem_rvalid is ignored: it is not forwarded, and if_valid and dm_valid are never asserted from IDLE.
- Reset mid-transaction: state returns to IDLE and mem_req drops on the next cycle. The memory is reset by the same RESET.
- Requester obligations: address and data fields are held stable while req is high. Requester protocol violations produce undefined results and are not checked.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - The counter increments, saturating, on each IDLE→SERV_D grant taken while if_req = 1 and if_flush = 0.
  - When the counter equals STARVE_LIMIT and if_req = 1 and if_flush = 0, the next IDLE arbitration grants IF even if dm_req = 1.
  - The counter clears on any IF grant and on RESET.
- Undefined: strict data priority; the counter logic is absent.

Test Plan:
- Reset then idle:
  - Stimulus: RESET high for 2 cycles, no requests.
  - Required: mem_req = 0, if_valid = dm_valid = 0, if_stall = dm_stall = 0, mem_addr = 0.
- Single fetch:
  - Stimulus: if_req = 1, if_addr = 0x100; memory returns mem_rdata = 0x00500093 two cycles after mem_req rises.
  - Required: mem_req = 1 with mem_addr = 0x100 and mem_we = 0; if_valid pulses once with if_rdata = 0x00500093; if_stall high every prior cycle.
- Simultaneous requests:
  - Stimulus: if_req and dm_req (store, dm_addr = 0x2000, dm_wdata = 0xDEADBEEF, dm_size = 2) rise together.
  - Required: DM served first with mem_we = 1 and the latched fields; after dm_valid, one IDLE cycle, then IF is served.
- Flush in flight:
  - Stimulus: SERV_I at 0x104; if_flush = 1 one cycle before mem_rvalid.
  - Required: no if_valid pulse; state returns to IDLE; the next fetch at 0x200 is served normally.
- Reset mid-transaction:
  - Stimulus: RESET asserted during SERV_D.
  - Required: mem_req = 0 next cycle, dm_valid never pulses, state = IDLE.
- Starvation (ARB_STARVE_GUARD_EN, STARVE_LIMIT = 4):
  - Stimulus: dm_req and if_req held continuously.
  - Required: grant sequence D, D, D, D, I, D, …; without the macro, IF is never granted.
